// File: rtl/router_in_arb_if.sv
// Handshake bundle between the packet sources, the round-robin arbiter and the router input port.
// master is the arbiter side; slave is the source/router side.
interface router_in_arb_if #(
    parameter int NSRC = 3
);
    logic [NSRC-1:0]   src_req;
    logic [NSRC-1:0]   src_pkt_valid;
    logic [8*NSRC-1:0] src_data;
    logic              busy;
    logic [NSRC-1:0]   gnt;
    logic [NSRC-1:0]   src_busy;
    logic              pkt_valid;
    logic [7:0]        data_in;
    logic              proto_err;

    modport master (
        input  src_req, src_pkt_valid, src_data, busy,
        output gnt, src_busy, pkt_valid, data_in, proto_err
    );

    modport slave (
        output src_req, src_pkt_valid, src_data, busy,
        input  gnt, src_busy, pkt_valid, data_in, proto_err
    );
endinterface

// File: rtl/router_in_arb.sv
// Round-robin arbiter granting the router input port to one source for a whole packet.
// Bytes are forwarded combinationally; the header length drives the end-of-packet count.
module router_in_arb #(
    parameter int NSRC = 3
) (
    input  logic            clk,
    input  logic            rst,
    router_in_arb_if.master bus
);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PARITY, GAP} state_t;

    state_t          state, state_nxt;
    logic [NSRC-1:0] gnt, gnt_nxt;
    logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]   cur, cur_nxt;
    logic [PW-1:0]   winner;
    logic            found;
    logic [5:0]      cnt, cnt_nxt;
    logic            proto_err, proto_err_nxt;
    logic            sel_valid;
    logic [7:0]      sel_data;
    logic            in_pkt;
    logic            accept;

    always_comb begin
        sel_valid = bus.src_pkt_valid[cur];
        sel_data  = bus.src_data[8*cur +: 8];
        in_pkt    = (state == HDR) || (state == PAYLOAD) || (state == PARITY);
        accept    = (|gnt) && in_pkt && !bus.busy;
    end

    // First requester at or above rr_ptr, wrapping; lowest offset wins.
    always_comb begin : arb_search
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NSRC;
            if (bus.src_req[idx]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        cnt_nxt       = cnt;
        rr_ptr_nxt    = rr_ptr;
        cur_nxt       = cur;
        proto_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (found && !bus.busy) begin
                    gnt_nxt         = '0;
                    gnt_nxt[winner] = 1'b1;
                    cur_nxt         = winner;
                    state_nxt       = HDR;
                end
            end
            HDR: begin
                if (accept && sel_valid) begin
                    cnt_nxt   = sel_data[7:2];
                    state_nxt = (sel_data[7:2] != 6'd0) ? PAYLOAD : PARITY;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (sel_valid) begin
                        cnt_nxt = cnt - 6'd1;
                        if (cnt == 6'd1) state_nxt = PARITY;
                    end else begin
                        // Short packet: this byte already went out as parity.
                        proto_err_nxt = 1'b1;
                        gnt_nxt       = '0;
                        state_nxt     = GAP;
                    end
                end
            end
            PARITY: begin
                if (accept) begin
                    proto_err_nxt = sel_valid;
                    gnt_nxt       = '0;
                    state_nxt     = GAP;
                end
            end
            GAP: begin
                rr_ptr_nxt = (cur == PW'(NSRC - 1)) ? '0 : cur + 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            cur       <= '0;
            cnt       <= 6'd0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            cur       <= cur_nxt;
            cnt       <= cnt_nxt;
            proto_err <= proto_err_nxt;
        end
    end

    // Parity is never flagged as valid so the router always sees end-of-packet.
    assign bus.gnt       = gnt;
    assign bus.src_busy  = ~gnt | {NSRC{bus.busy}};
    assign bus.data_in   = in_pkt ? sel_data : 8'h00;
    assign bus.pkt_valid = ((state == HDR) || (state == PAYLOAD)) ? sel_valid : 1'b0;
    assign bus.proto_err = proto_err;
endmodule

// File: tb/tb_router_in_arb.sv
// Scoreboard bench for router_in_arb: sources replay byte queues, the monitor pops expected bytes per grant.
module tb_router_in_arb;
    localparam int NSRC = 3;

    logic clk = 1'b0;
    logic rst;

    router_in_arb_if #(.NSRC(NSRC)) bus ();

    router_in_arb #(.NSRC(NSRC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0]      src_q [NSRC][$];
    logic [8:0]      exp_q [NSRC][$];
    logic [NSRC-1:0] gq [$];
    logic [NSRC-1:0] adv;
    logic            busy_drv;
    logic            rst_drv;
    int              acc_cnt;
    int              perr_cnt;
    int              zero_run;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic load_pkt(input int s, input logic [7:0] hdr, input int npay);
        logic [7:0] par;
        logic [7:0] b;
        par = hdr;
        src_q[s].push_back({1'b1, hdr});
        exp_q[s].push_back({1'b1, hdr});
        for (int k = 0; k < npay; k++) begin
            b = 8'($urandom_range(0, 255));
            par ^= b;
            src_q[s].push_back({1'b1, b});
            exp_q[s].push_back({1'b1, b});
        end
        src_q[s].push_back({1'b0, par});
        exp_q[s].push_back({1'b0, par});
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < NSRC; i++) if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic cycle();
        int s;
        logic [8:0] e;
        @(posedge clk);
        #1;
        for (int i = 0; i < NSRC; i++)
            if (adv[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        adv = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_q[i].size() > 0) begin
                bus.src_req[i]          = 1'b1;
                bus.src_pkt_valid[i]    = src_q[i][0][8];
                bus.src_data[8*i +: 8]  = src_q[i][0][7:0];
            end else begin
                bus.src_req[i]          = 1'b0;
                bus.src_pkt_valid[i]    = 1'b0;
                bus.src_data[8*i +: 8]  = 8'h00;
            end
        end
        bus.busy = busy_drv;
        rst      = rst_drv;
        @(negedge clk);
        if (!rst_drv) return;
        if (bus.proto_err) perr_cnt++;
        if (bus.gnt == '0) begin
            zero_run++;
        end else begin
            if (zero_run > 0) begin
                check_eq("idle_gap", 32'(zero_run >= 2), 32'd1);
                check_eq("gnt_onehot", 32'($countones(bus.gnt)), 32'd1);
                if (gq.size() > 0) check_eq("gnt_order", 32'(bus.gnt), 32'(gq.pop_front()));
            end
            zero_run = 0;
            if (!bus.busy) begin
                s = 0;
                for (int i = 0; i < NSRC; i++) if (bus.gnt[i]) s = i;
                acc_cnt++;
                adv[s] = 1'b1;
                if (exp_q[s].size() == 0) begin
                    check_eq("extra_byte", 32'(exp_q[s].size()), 32'd1);
                end else begin
                    e = exp_q[s].pop_front();
                    check_eq("data_in", 32'(bus.data_in), 32'(e[7:0]));
                    check_eq("pkt_valid", 32'(bus.pkt_valid), 32'(e[8]));
                end
            end
        end
    endtask

    task automatic run_done(input int max);
        int n;
        n = 0;
        while ((pending() || bus.gnt != '0) && n < max) begin
            cycle();
            n++;
        end
        check_eq("timeout", 32'(n < max), 32'd1);
        cycle();
        cycle();
        for (int i = 0; i < NSRC; i++) check_eq("exp_left", 32'(exp_q[i].size()), 32'd0);
        check_eq("gnt_left", 32'(gq.size()), 32'd0);
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 100) begin
            cycle();
            n++;
        end
        check_eq("wait_acc", 32'(acc_cnt), 32'(target));
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        cycle();
        cycle();
        rst_drv = 1'b1;
        cycle();
    endtask

    initial begin
        rst               = 1'b0;
        bus.src_req       = '0;
        bus.src_pkt_valid = '0;
        bus.src_data      = '0;
        bus.busy          = 1'b0;
        adv               = '0;
        busy_drv          = 1'b0;
        rst_drv           = 1'b0;
        acc_cnt           = 0;
        perr_cnt          = 0;
        zero_run          = 0;

        do_reset();
        check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        check_eq("rst_data_in", 32'(bus.data_in), 32'd0);
        check_eq("rst_src_busy", 32'(bus.src_busy), 32'b111);
        check_eq("rst_proto_err", 32'(bus.proto_err), 32'd0);
        check_eq("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // Single source, len 14
        acc_cnt = 0;
        load_pkt(0, 8'h38, 14);
        gq.push_back(3'b001);
        cycle();
        check_eq("gnt_before", 32'(bus.gnt), 32'd0);
        cycle();
        check_eq("gnt_1cyc", 32'(bus.gnt), 32'b001);
        run_done(300);
        check_eq("t1_acc", 32'(acc_cnt), 32'd16);
        check_eq("t1_rr_ptr", 32'(dut.rr_ptr), 32'd1);
        check_eq("t1_gnt_end", 32'(bus.gnt), 32'd0);

        // Three simultaneous requests after a fresh reset
        do_reset();
        acc_cnt = 0;
        load_pkt(0, 8'h31, 12);
        load_pkt(1, 8'h42, 16);
        load_pkt(2, 8'h4E, 19);
        gq.push_back(3'b001);
        gq.push_back(3'b010);
        gq.push_back(3'b100);
        run_done(400);
        check_eq("t2_acc", 32'(acc_cnt), 32'd53);
        check_eq("t2_rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // busy stall mid-payload
        acc_cnt = 0;
        load_pkt(1, 8'h20, 8);
        gq.push_back(3'b010);
        wait_acc(5);
        busy_drv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("busy_cnt_hold", 32'(dut.cnt), 32'd4);
            check_eq("busy_data_hold", 32'(bus.data_in), 32'(exp_q[1][0][7:0]));
            check_eq("busy_src_busy", 32'(bus.src_busy[1]), 32'd1);
            check_eq("busy_gnt", 32'(bus.gnt), 32'b010);
        end
        busy_drv = 1'b0;
        run_done(300);
        check_eq("t3_acc", 32'(acc_cnt), 32'd10);

        // Zero-length packet
        acc_cnt  = 0;
        perr_cnt = 0;
        load_pkt(2, 8'h00, 0);
        gq.push_back(3'b100);
        run_done(100);
        check_eq("t4_acc", 32'(acc_cnt), 32'd2);
        check_eq("t4_proto_err", 32'(perr_cnt), 32'd0);

        // Short packet: header says 10, only 6 payload bytes; next requester follows
        acc_cnt  = 0;
        perr_cnt = 0;
        load_pkt(0, 8'h28, 6);
        load_pkt(1, 8'h0C, 3);
        gq.push_back(3'b001);
        gq.push_back(3'b010);
        run_done(300);
        check_eq("t5_proto_err", 32'(perr_cnt), 32'd1);
        check_eq("t5_acc", 32'(acc_cnt), 32'd13);
        check_eq("t5_rr_ptr", 32'(dut.rr_ptr), 32'd2);

        // Reset in the middle of a len-16 payload
        acc_cnt = 0;
        load_pkt(2, 8'h40, 16);
        gq.push_back(3'b100);
        wait_acc(5);
        rst_drv = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        gq.delete();
        adv = '0;
        cycle();
        rst_drv = 1'b1;
        cycle();
        check_eq("mrst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("mrst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        check_eq("mrst_data_in", 32'(bus.data_in), 32'd0);
        check_eq("mrst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        check_eq("mrst_cnt", 32'(dut.cnt), 32'd0);
        check_eq("mrst_src_busy", 32'(bus.src_busy), 32'b111);
        acc_cnt = 0;
        load_pkt(0, 8'h08, 2);
        load_pkt(2, 8'h04, 1);
        gq.push_back(3'b001);
        gq.push_back(3'b100);
        run_done(200);
        check_eq("t6_acc", 32'(acc_cnt), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
